// File: rtl/fifo_ctrl_subword_if.sv
// Handshake and status bundle between a sub-word FIFO controller and its user.
interface fifo_ctrl_subword_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RATIO      = 2
);
    localparam int unsigned SW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                  wr;
    logic                  rd;
    logic                  clr_err;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [SW-1:0]         sub_sel;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  ovf;
    logic                  udf;

    modport master (
        output wr, rd, clr_err,
        input  w_addr, r_addr, sub_sel, count, empty, full,
               almost_empty, almost_full, ovf, udf
    );

    modport slave (
        input  wr, rd, clr_err,
        output w_addr, r_addr, sub_sel, count, empty, full,
               almost_empty, almost_full, ovf, udf
    );
endinterface

// File: rtl/fifo_ctrl_subword.sv
// Circular-queue controller: whole-entry writes, sub-word reads (MS sub-word first),
// with occupancy count, programmable almost flags and sticky error flags.
module fifo_ctrl_subword #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RATIO      = 2,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_ctrl_subword_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SW-1:0] SUB_TOP = SW'(RATIO - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr,  wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr,  rd_ptr_nxt;
    logic [SW-1:0]         sub_q,   sub_nxt;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  ovf_q,   ovf_nxt;
    logic                  udf_q,   udf_nxt;
    logic                  empty_q, empty_nxt;
    logic                  full_q,  full_nxt;
    logic                  ae_q,    ae_nxt;
    logic                  af_q,    af_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  free_c;

    // Acceptance, pointer/sub-word advance and occupancy for this edge.
    always_comb begin
        wr_acc     = bus.wr & ~full_q;
        rd_acc     = bus.rd & ~empty_q;
        free_c     = rd_acc & (sub_q == '0);
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        sub_nxt    = sub_q;

        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
        end

        if (rd_acc) begin
            if (sub_q != '0) begin
                sub_nxt = sub_q - SW'(1);
            end else begin
                sub_nxt    = SUB_TOP;
                rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
            end
        end

        count_nxt = count_q + CW'(wr_acc) - CW'(free_c);
    end

    // Flags are registered from the next count so they track count exactly.
    always_comb begin
        empty_nxt = (count_nxt == '0);
        full_nxt  = (count_nxt == CW'(DEPTH));
        ae_nxt    = (32'(count_nxt) <= 32'(AE_LEVEL));
        af_nxt    = (32'(count_nxt) >= 32'(AF_LEVEL));
    end

    // Sticky errors: a new error outranks a clear in the same cycle.
    always_comb begin
        ovf_nxt = ovf_q;
        udf_nxt = udf_q;
        if (bus.wr & full_q) begin
            ovf_nxt = 1'b1;
        end else if (bus.clr_err) begin
            ovf_nxt = 1'b0;
        end
        if (bus.rd & empty_q) begin
            udf_nxt = 1'b1;
        end else if (bus.clr_err) begin
            udf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sub_q   <= SUB_TOP;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            sub_q   <= sub_nxt;
            count_q <= count_nxt;
            ovf_q   <= ovf_nxt;
            udf_q   <= udf_nxt;
            empty_q <= empty_nxt;
            full_q  <= full_nxt;
            ae_q    <= ae_nxt;
            af_q    <= af_nxt;
        end
    end

    assign bus.w_addr       = wr_ptr;
    assign bus.r_addr       = rd_ptr;
    assign bus.sub_sel      = sub_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;
endmodule

// File: tb/tb_fifo_ctrl_subword.sv
// Bench for fifo_ctrl_subword: RATIO=2 and RATIO=4 instances, each with a model register file.
module tb_fifo_ctrl_subword;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    fifo_ctrl_subword_if #(.ADDR_WIDTH(AW), .RATIO(2)) if2 ();
    fifo_ctrl_subword_if #(.ADDR_WIDTH(AW), .RATIO(4)) if4 ();

    fifo_ctrl_subword #(.ADDR_WIDTH(AW), .RATIO(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    fifo_ctrl_subword #(.ADDR_WIDTH(AW), .RATIO(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    // Register files written by the controllers' write enables
    logic [15:0] mem2 [DEPTH];
    logic [31:0] mem4 [DEPTH];
    logic [15:0] wdata2;
    logic [31:0] wdata4;
    always @(posedge clk) if (if2.wr && !if2.full) mem2[if2.w_addr] <= wdata2;
    always @(posedge clk) if (if4.wr && !if4.full) mem4[if4.w_addr] <= wdata4;

    // Reference state for the RATIO=2 instance plus sub-word scoreboard
    int         m_cnt, m_w, m_r, m_sub;
    logic [7:0] sb [$];

    task automatic model_reset();
        m_cnt = 0; m_w = 0; m_r = 0; m_sub = 1;
        sb.delete();
    endtask

    // One cycle on the RATIO=2 instance; accepted reads are checked against the scoreboard.
    task automatic step2(input bit w, input bit r, input bit c, input logic [15:0] d);
        bit         wa, ra, fr;
        logic [7:0] got, exp;
        if2.wr = w; if2.rd = r; if2.clr_err = c; wdata2 = d;
        wa = w && (m_cnt != DEPTH);
        ra = r && (m_cnt != 0);
        fr = ra && (m_sub == 0);
        if (ra) begin
            got = (if2.sub_sel != 0) ? mem2[if2.r_addr][15:8] : mem2[if2.r_addr][7:0];
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_data: got %h but scoreboard empty", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rd_data: got %h want %h", got, exp);
                end
            end
        end
        if (wa) begin
            sb.push_back(d[15:8]);
            sb.push_back(d[7:0]);
            m_w = (m_w + 1) % DEPTH;
        end
        if (ra) begin
            if (m_sub != 0) m_sub = m_sub - 1;
            else begin m_sub = 1; m_r = (m_r + 1) % DEPTH; end
        end
        m_cnt = m_cnt + int'(wa) - int'(fr);
        @(posedge clk); #1;
    endtask

    task automatic step4(input bit w, input bit r, input bit c, input logic [31:0] d);
        if4.wr = w; if4.rd = r; if4.clr_err = c; wdata4 = d;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (if2.empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b want 1", if2.empty); end
        checks++; if (if2.count !== 5'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", if2.count); end
        checks++; if (if2.sub_sel !== 1'b1) begin failures++; $display("FAIL rst_sub2: got %0d want 1", if2.sub_sel); end
        checks++; if (if4.sub_sel !== 2'd3) begin failures++; $display("FAIL rst_sub4: got %0d want 3", if4.sub_sel); end
        checks++; if ({if2.ovf, if2.udf} !== 2'b00) begin failures++; $display("FAIL rst_err: got %b want 00", {if2.ovf, if2.udf}); end
        checks++; if ({if2.full, if2.almost_empty, if2.almost_full} !== 3'b010) begin
            failures++; $display("FAIL rst_flags: got %b want 010", {if2.full, if2.almost_empty, if2.almost_full}); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step2(1'b1, 1'b0, 1'b0, 16'h1111);
        checks++; if (if2.count !== 5'd3) begin failures++; $display("FAIL burst_count: got %0d want 3", if2.count); end
        // Asynchronous reset mid-burst, observed before the next edge
        #2 reset = 1'b1;
        #1;
        checks++; if (if2.count !== 5'd0 || if2.empty !== 1'b1) begin
            failures++; $display("FAIL async_rst: got count=%0d empty=%b want 0/1", if2.count, if2.empty); end
        checks++; if (if2.w_addr !== 4'd0 || if2.sub_sel !== 1'b1) begin
            failures++; $display("FAIL async_rst_ptr: got w_addr=%0d sub=%0d want 0/1", if2.w_addr, if2.sub_sel); end
        if2.wr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 16; i++) begin
            step2(1'b1, 1'b0, 1'b0, {8'(8'h10 + i), 8'(8'h80 + i)});
            checks++; if (if2.count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count: got %0d want %0d", if2.count, i + 1); end
            checks++; if (if2.almost_full !== (i + 1 >= 14)) begin failures++; $display("FAIL fill_af: got %b at count %0d", if2.almost_full, i + 1); end
            checks++; if (if2.almost_empty !== (i + 1 <= 1)) begin failures++; $display("FAIL fill_ae: got %b at count %0d", if2.almost_empty, i + 1); end
            checks++; if (if2.full !== (i == 15)) begin failures++; $display("FAIL fill_full: got %b at count %0d", if2.full, i + 1); end
        end
        step2(1'b1, 1'b0, 1'b0, 16'hDEAD);
        checks++; if (if2.ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", if2.ovf); end
        checks++; if (if2.w_addr !== 4'd0 || if2.count !== 5'd16) begin
            failures++; $display("FAIL ovf_hold: got w_addr=%0d count=%0d want 0/16", if2.w_addr, if2.count); end
        step2(1'b0, 1'b0, 1'b1, 16'h0);
        checks++; if (if2.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", if2.ovf); end
    endtask

    task automatic test_full_rdwr();
        step2(1'b1, 1'b1, 1'b0, 16'hBEEF);
        checks++; if (if2.count !== 5'd16 || if2.sub_sel !== 1'b0 || if2.ovf !== 1'b1) begin
            failures++; $display("FAIL full_rw1: got count=%0d sub=%0d ovf=%b want 16/0/1", if2.count, if2.sub_sel, if2.ovf); end
        step2(1'b1, 1'b1, 1'b0, 16'hCAFE);
        checks++; if (if2.count !== 5'd15 || if2.r_addr !== 4'd1 || if2.w_addr !== 4'd0) begin
            failures++; $display("FAIL full_rw2: got count=%0d r=%0d w=%0d want 15/1/0", if2.count, if2.r_addr, if2.w_addr); end
        step2(1'b1, 1'b1, 1'b0, 16'h5AA5);
        checks++; if (if2.count !== 5'd16 || if2.w_addr !== 4'd1) begin
            failures++; $display("FAIL full_rw3: got count=%0d w=%0d want 16/1", if2.count, if2.w_addr); end
        step2(1'b0, 1'b0, 1'b1, 16'h0);
        for (int n = 0; n < 64 && m_cnt > 0; n++) step2(1'b0, 1'b1, 1'b0, 16'h0);
        checks++; if (if2.empty !== 1'b1 || if2.count !== 5'd0 || m_cnt != 0) begin
            failures++; $display("FAIL drain: got empty=%b count=%0d want 1/0", if2.empty, if2.count); end
    endtask

    task automatic test_ratio4();
        logic [7:0]  e [4];
        logic [31:0] wv;
        int          s;
        e[0] = 8'hA1; e[1] = 8'hB2; e[2] = 8'hC3; e[3] = 8'hD4;
        step4(1'b1, 1'b0, 1'b0, 32'hA1B2C3D4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (if4.sub_sel !== 2'(3 - i) || if4.r_addr !== 4'd0) begin
                failures++; $display("FAIL r4_sel: got sub=%0d r=%0d want %0d/0", if4.sub_sel, if4.r_addr, 3 - i); end
            wv = mem4[if4.r_addr];
            s  = int'(if4.sub_sel);
            checks++; if (wv[s*8 +: 8] !== e[i]) begin failures++; $display("FAIL r4_data: got %h want %h", wv[s*8 +: 8], e[i]); end
            step4(1'b0, 1'b1, 1'b0, 32'h0);
        end
        checks++; if (if4.empty !== 1'b1 || if4.r_addr !== 4'd1 || if4.sub_sel !== 2'd3) begin
            failures++; $display("FAIL r4_done: got empty=%b r=%0d sub=%0d want 1/1/3", if4.empty, if4.r_addr, if4.sub_sel); end
        step4(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (if4.udf !== 1'b1 || if4.r_addr !== 4'd1 || if4.sub_sel !== 2'd3) begin
            failures++; $display("FAIL r4_udf: got udf=%b r=%0d sub=%0d want 1/1/3", if4.udf, if4.r_addr, if4.sub_sel); end
        step4(1'b0, 1'b0, 1'b1, 32'h0);
        checks++; if (if4.udf !== 1'b0) begin failures++; $display("FAIL r4_clr: got %b want 0", if4.udf); end
    endtask

    task automatic test_empty_rdwr();
        logic [3:0] r0;
        r0 = if2.r_addr;
        step2(1'b1, 1'b1, 1'b0, 16'h5A6B);
        checks++; if (if2.count !== 5'd1 || if2.udf !== 1'b1 || if2.sub_sel !== 1'b1 || if2.r_addr !== r0) begin
            failures++; $display("FAIL empty_rw: got count=%0d udf=%b sub=%0d r=%0d want 1/1/1/%0d",
                                 if2.count, if2.udf, if2.sub_sel, if2.r_addr, r0); end
        step2(1'b0, 1'b0, 1'b1, 16'h0);
        checks++; if ({if2.ovf, if2.udf} !== 2'b00) begin failures++; $display("FAIL clr_err: got %b want 00", {if2.ovf, if2.udf}); end
        step2(1'b0, 1'b1, 1'b0, 16'h0);
        step2(1'b0, 1'b1, 1'b0, 16'h0);
        checks++; if (if2.empty !== 1'b1) begin failures++; $display("FAIL empty_drain: got %b want 1", if2.empty); end
    endtask

    task automatic test_wrap();
        int         wl, rl, cyc, pick;
        bit         w, r, wrap_w, wrap_r;
        logic [3:0] pw, pr;
        wl = 40; rl = 80; wrap_w = 0; wrap_r = 0;
        for (cyc = 0; cyc < 400 && (wl > 0 || m_cnt > 0); cyc++) begin
            pw = if2.w_addr; pr = if2.r_addr;
            if (m_cnt == 0) begin w = 1; r = 0; end
            else if (wl == 0 || m_cnt == DEPTH) begin w = 0; r = 1; end
            else begin
                pick = int'($urandom_range(0, 3));
                w = (pick != 2); r = (pick >= 2);
            end
            if (w) wl--;
            if (r) rl--;
            step2(w, r, 1'b0, 16'($urandom));
            checks++; if (if2.count !== 5'(m_cnt) || if2.count > 5'd16) begin
                failures++; $display("FAIL wrap_count: got %0d want %0d", if2.count, m_cnt); end
            checks++; if (if2.w_addr !== 4'(m_w) || if2.r_addr !== 4'(m_r)) begin
                failures++; $display("FAIL wrap_ptr: got w=%0d r=%0d want %0d/%0d", if2.w_addr, if2.r_addr, m_w, m_r); end
            if (pw == 4'd15 && if2.w_addr == 4'd0) wrap_w = 1;
            if (pr == 4'd15 && if2.r_addr == 4'd0) wrap_r = 1;
        end
        checks++; if (wl != 0 || rl != 0 || m_cnt != 0) begin
            failures++; $display("FAIL wrap_timeout: got wl=%0d rl=%0d cnt=%0d want 0/0/0", wl, rl, m_cnt); end
        checks++; if (!(wrap_w && wrap_r)) begin failures++; $display("FAIL wrap_seen: got w=%b r=%b want 1/1", wrap_w, wrap_r); end
        checks++; if ({if2.ovf, if2.udf} !== 2'b00) begin failures++; $display("FAIL wrap_err: got %b want 00", {if2.ovf, if2.udf}); end
    endtask

    initial begin
        if2.wr = 1'b0; if2.rd = 1'b0; if2.clr_err = 1'b0;
        if4.wr = 1'b0; if4.rd = 1'b0; if4.clr_err = 1'b0;
        wdata2 = '0; wdata4 = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill_full();
        test_full_rdwr();
        test_ratio4();
        test_empty_rdwr();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
